// File: rtl/parfir_block_sequencer.sv
// Block sequencer for an L-parallel FIR bank: gathers L samples per block, pulses the
// bank enable, skips results until the bank pipeline is primed, then reserialises each result block.
module parfir_block_sequencer_lane #(
    parameter int DW_IN  = 16,
    parameter int DW_OUT = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              x_we,
    input  logic [DW_IN-1:0]  x_d,
    output logic [DW_IN-1:0]  x_q,
    input  logic              y_ld,
    input  logic [DW_OUT-1:0] y_d,
    output logic [DW_OUT-1:0] y_q
);
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            if (x_we) x_q <= x_d;
            if (y_ld) y_q <= y_d;
        end
    end
endmodule

module parfir_block_sequencer #(
    parameter int L        = 3,
    parameter int PIPE_LAT = 2,
    parameter int DW_IN    = 16,
    parameter int DW_OUT   = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DW_IN-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [L*DW_IN-1:0]    blk_x,
    output logic                  blk_en,
    input  logic [L*DW_OUT-1:0]   blk_y,
    output logic [DW_OUT-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  primed
);
    localparam int PW = (L > 2) ? 2 : 1;
    localparam int CW = $clog2(PIPE_LAT + 1);

    logic [PW-1:0]                 phase, out_idx;
    logic [CW-1:0]                 prime_cnt;
    logic                          full, cap_pending, obuf_busy;
    logic                          accept, issue, cap_set, out_hs;
    logic [L-1:0][DW_IN-1:0]       x_q;
    logic [L-1:0][DW_OUT-1:0]      y_d, obuf_q;

    assign accept  = in_valid && !full;
    // A block only leaves once the previous result has fully drained.
    assign issue   = full && !obuf_busy && !cap_pending;
    assign cap_set = issue && (prime_cnt >= CW'(PIPE_LAT - 1));
    assign out_hs  = obuf_busy && out_ready;

    assign in_ready  = !full;
    assign blk_en    = issue;
    assign blk_x     = x_q;
    assign y_d       = blk_y;
    assign out_valid = obuf_busy;
    assign out_data  = obuf_q[out_idx];
    assign primed    = (prime_cnt == CW'(PIPE_LAT));

    for (genvar i = 0; i < L; i++) begin : g_lane
        parfir_block_sequencer_lane #(.DW_IN(DW_IN), .DW_OUT(DW_OUT)) u_lane (
            .clk   (clk),
            .reset (reset),
            .x_we  (accept && (phase == PW'(i))),
            .x_d   (in_data),
            .x_q   (x_q[i]),
            .y_ld  (cap_pending),
            .y_d   (y_d[i]),
            .y_q   (obuf_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase       <= '0;
            full        <= 1'b0;
            prime_cnt   <= '0;
            cap_pending <= 1'b0;
            obuf_busy   <= 1'b0;
            out_idx     <= '0;
        end else begin
            if (accept) begin
                if (phase == PW'(L - 1)) begin
                    phase <= '0;
                    full  <= 1'b1;
                end else begin
                    phase <= phase + PW'(1);
                end
            end else if (issue) begin
                full <= 1'b0;
            end

            if (issue && !primed) prime_cnt <= prime_cnt + CW'(1);

            // Bank output for a capturing block is valid the cycle after its enable.
            if (cap_pending) begin
                cap_pending <= 1'b0;
                obuf_busy   <= 1'b1;
                out_idx     <= '0;
            end else if (cap_set) begin
                cap_pending <= 1'b1;
            end else if (out_hs) begin
                if (out_idx == PW'(L - 1)) begin
                    obuf_busy <= 1'b0;
                    out_idx   <= '0;
                end else begin
                    out_idx <= out_idx + PW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_parfir_block_sequencer.sv
// Directed bench for parfir_block_sequencer: an L=3 and an L=2 instance, each with a
// one-stage stub bank that sign-extends the enabled block.
module tb_parfir_block_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [15:0] in_data3, in_data2;
    logic        in_valid3, in_valid2, in_ready3, in_ready2;
    logic [47:0] blk_x3;
    logic [31:0] blk_x2;
    logic        blk_en3, blk_en2;
    logic [71:0] blk_y3;
    logic [47:0] blk_y2;
    logic [23:0] out_data3, out_data2;
    logic        out_valid3, out_valid2, out_ready3, out_ready2, primed3, primed2;

    parfir_block_sequencer #(.L(3), .PIPE_LAT(2), .DW_IN(16), .DW_OUT(24)) dut3 (
        .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .blk_x(blk_x3), .blk_en(blk_en3), .blk_y(blk_y3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .primed(primed3));

    parfir_block_sequencer #(.L(2), .PIPE_LAT(2), .DW_IN(16), .DW_OUT(24)) dut2 (
        .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .blk_x(blk_x2), .blk_en(blk_en2), .blk_y(blk_y2), .out_data(out_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .primed(primed2));

    always @(posedge clk) begin
        if (blk_en3)
            for (int i = 0; i < 3; i++) blk_y3[i*24 +: 24] <= {{8{blk_x3[i*16+15]}}, blk_x3[i*16 +: 16]};
        if (blk_en2)
            for (int i = 0; i < 2; i++) blk_y2[i*24 +: 24] <= {{8{blk_x2[i*16+15]}}, blk_x2[i*16 +: 16]};
    end

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [47:0] en3[$];
    logic [31:0] en2[$];
    logic [23:0] out3[$], out2[$];
    int enc3[$], ency3[$], accy3[$], outy3[$];
    logic pr3[$];
    int acc3, ovf3;

    task automatic clear_logs();
        en3.delete(); en2.delete(); out3.delete(); out2.delete();
        enc3.delete(); ency3.delete(); accy3.delete(); outy3.delete(); pr3.delete();
        acc3 = 0; ovf3 = -1;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (blk_en3) begin
                en3.push_back(blk_x3); enc3.push_back(acc3); ency3.push_back(cyc); pr3.push_back(primed3);
            end
            if (in_valid3 && in_ready3) begin acc3++; accy3.push_back(cyc); end
            if (out_valid3 && out_ready3) begin out3.push_back(out_data3); outy3.push_back(cyc); end
            if (out_valid3 && ovf3 < 0) ovf3 = cyc;
            if (blk_en2) en2.push_back(blk_x2);
            if (out_valid2 && out_ready2) out2.push_back(out_data2);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
        clear_logs();
    endtask

    task automatic send(input bit two, input int first, input int n, input bit gap);
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            bit ok;
            ok = 1'b0;
            if (two) begin in_data2 = 16'(first + k); in_valid2 = 1'b1; end
            else     begin in_data3 = 16'(first + k); in_valid3 = 1'b1; end
            for (int w = 0; w < 200 && !ok; w++) begin
                @(negedge clk);
                ok = two ? in_ready2 : in_ready3;
            end
            if (!ok) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: sample %0d never accepted within 200 cycles", first + k);
            end
            @(posedge clk); #1;
            if (gap) begin
                in_valid2 = 1'b0; in_valid3 = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid2 = 1'b0; in_valid3 = 1'b0;
    endtask

    task automatic wait_outs(input bit two, input int n);
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < 300 && !ok; w++) begin
            @(negedge clk);
            ok = two ? (out2.size() >= n) : (out3.size() >= n);
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL wait_outs: got %0d outputs, required %0d", two ? out2.size() : out3.size(), n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_l3_stream(input string tag);
        n_cmp++;
        if (en3.size() != 3) begin n_err++; $display("FAIL %s_en_count: got %0d required 3", tag, en3.size()); end
        for (int k = 0; k < 3 && k < en3.size(); k++) begin
            logic [47:0] exp_x;
            exp_x = {16'(3*k+3), 16'(3*k+2), 16'(3*k+1)};
            n_cmp++;
            if (en3[k] !== exp_x) begin n_err++; $display("FAIL %s_blk_x[%0d]: got %h required %h", tag, k, en3[k], exp_x); end
            n_cmp++;
            if (enc3[k] !== 3*k+3) begin n_err++; $display("FAIL %s_en_after_accepts[%0d]: got %0d required %0d", tag, k, enc3[k], 3*k+3); end
        end
        n_cmp++;
        if (out3.size() != 6) begin n_err++; $display("FAIL %s_out_count: got %0d required 6", tag, out3.size()); end
        for (int k = 0; k < 6 && k < out3.size(); k++) begin
            n_cmp++;
            if (out3[k] !== 24'(4 + k)) begin n_err++; $display("FAIL %s_out[%0d]: got %0d required %0d", tag, k, out3[k], 4 + k); end
        end
        n_cmp++;
        if (in_ready3 !== 1'b1 || out_valid3 !== 1'b0) begin
            n_err++; $display("FAIL %s_idle_after: in_ready=%b out_valid=%b required 1/0", tag, in_ready3, out_valid3);
        end
    endtask

    task automatic test_reset();
        do_reset(2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({in_ready3, blk_en3, out_valid3, primed3} !== 4'b1000 || out_data3 !== 24'd0) begin
                n_err++;
                $display("FAIL reset_idle3 cyc %0d: rdy/en/ov/pr=%b%b%b%b data=%0d required 1000 data 0",
                         i, in_ready3, blk_en3, out_valid3, primed3, out_data3);
            end
            n_cmp++;
            if ({in_ready2, blk_en2, out_valid2, primed2} !== 4'b1000) begin
                n_err++;
                $display("FAIL reset_idle2 cyc %0d: rdy/en/ov/pr=%b%b%b%b required 1000",
                         i, in_ready2, blk_en2, out_valid2, primed2);
            end
        end
    endtask

    task automatic test_streaming();
        do_reset(1);
        out_ready3 = 1'b1;
        send(1'b0, 1, 9, 1'b0);
        wait_outs(1'b0, 6);
        check_l3_stream("stream");
        n_cmp++;
        if (pr3.size() != 3 || pr3[0] !== 1'b0 || pr3[1] !== 1'b0 || pr3[2] !== 1'b1) begin
            n_err++; $display("FAIL stream_primed_at_issues: got %p required 0,0,1", pr3);
        end
        if (ency3.size() >= 2 && accy3.size() >= 6) begin
            n_cmp++;
            if (ency3[1] - accy3[5] != 1) begin
                n_err++; $display("FAIL stream_accept_to_en: got %0d required 1", ency3[1] - accy3[5]);
            end
            n_cmp++;
            if (ovf3 - ency3[1] != 2) begin
                n_err++; $display("FAIL stream_en_to_out_valid: got %0d required 2", ovf3 - ency3[1]);
            end
        end
    endtask

    task automatic test_back_pressure();
        do_reset(1);
        out_ready3 = 1'b0;
        fork
            send(1'b0, 1, 9, 1'b0);
            begin
                bit seen;
                seen = 1'b0;
                for (int w = 0; w < 300 && !seen; w++) begin
                    @(negedge clk);
                    seen = out_valid3;
                end
                n_cmp++;
                if (!seen) begin n_err++; $display("FAIL bp_out_valid_timeout: out_valid never rose"); end
                for (int i = 0; i < 10; i++) begin
                    if (i > 0) @(negedge clk);
                    n_cmp++;
                    if (out_valid3 !== 1'b1 || out_data3 !== 24'd4 || blk_en3 !== 1'b0) begin
                        n_err++; $display("FAIL bp_hold cyc %0d: ov=%b data=%0d en=%b required 1/4/0", i, out_valid3, out_data3, blk_en3);
                    end
                    if (i >= 5) begin
                        n_cmp++;
                        if (in_ready3 !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc %0d: got %b required 0", i, in_ready3); end
                    end
                end
                @(posedge clk); #1;
                out_ready3 = 1'b1;
            end
        join
        wait_outs(1'b0, 6);
        check_l3_stream("bp");
        if (ency3.size() >= 3 && outy3.size() >= 3) begin
            n_cmp++;
            if (ency3[2] <= outy3[2]) begin
                n_err++; $display("FAIL bp_third_en_wait: en cycle %0d required after last handshake %0d", ency3[2], outy3[2]);
            end
        end
    endtask

    task automatic test_gapped();
        do_reset(1);
        out_ready3 = 1'b1;
        send(1'b0, 1, 9, 1'b1);
        wait_outs(1'b0, 6);
        check_l3_stream("gap");
    endtask

    task automatic test_mid_reset();
        do_reset(1);
        out_ready3 = 1'b1;
        send(1'b0, 1, 2, 1'b0);
        do_reset(1);
        send(1'b0, 10, 3, 1'b0);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (en3.size() != 1) begin n_err++; $display("FAIL midrst_en_count: got %0d required 1", en3.size()); end
        if (en3.size() >= 1) begin
            n_cmp++;
            if (en3[0] !== {16'd12, 16'd11, 16'd10}) begin
                n_err++; $display("FAIL midrst_blk_x: got %h required %h", en3[0], {16'd12, 16'd11, 16'd10});
            end
        end
        n_cmp++;
        if (primed3 !== 1'b0 || out_valid3 !== 1'b0 || ovf3 != -1) begin
            n_err++; $display("FAIL midrst_no_capture: primed=%b out_valid=%b first_ov=%0d required 0/0/-1", primed3, out_valid3, ovf3);
        end
    endtask

    task automatic test_l2();
        do_reset(1);
        out_ready2 = 1'b1;
        send(1'b1, 1, 6, 1'b0);
        wait_outs(1'b1, 4);
        n_cmp++;
        if (en2.size() != 3) begin n_err++; $display("FAIL l2_en_count: got %0d required 3", en2.size()); end
        for (int k = 0; k < 3 && k < en2.size(); k++) begin
            logic [31:0] exp_x;
            exp_x = {16'(2*k+2), 16'(2*k+1)};
            n_cmp++;
            if (en2[k] !== exp_x) begin n_err++; $display("FAIL l2_blk_x[%0d]: got %h required %h", k, en2[k], exp_x); end
        end
        n_cmp++;
        if (out2.size() != 4) begin n_err++; $display("FAIL l2_out_count: got %0d required 4", out2.size()); end
        for (int k = 0; k < 4 && k < out2.size(); k++) begin
            n_cmp++;
            if (out2[k] !== 24'(3 + k)) begin n_err++; $display("FAIL l2_out[%0d]: got %0d required %0d", k, out2[k], 3 + k); end
        end
        n_cmp++;
        if (primed2 !== 1'b1) begin n_err++; $display("FAIL l2_primed: got %b required 1", primed2); end
    endtask

    initial begin
        reset = 1'b1;
        in_data3 = '0; in_data2 = '0;
        in_valid3 = 1'b0; in_valid2 = 1'b0;
        out_ready3 = 1'b1; out_ready2 = 1'b1;
        clear_logs();
        fork monitor(); join_none
        test_reset();
        test_streaming();
        test_back_pressure();
        test_gapped();
        test_mid_reset();
        test_l2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
